// File: rtl/rgb_to_gray_pkg.sv
// Shared types and constants for the RGB-to-grayscale pipeline: channel widths,
// pixel field offsets and the feeder state encoding.
package rgb_to_gray_pkg;

  localparam int unsigned CH_W  = 8;
  localparam int unsigned PIX_W = 3 * CH_W;

  localparam int unsigned R_LSB = 16;
  localparam int unsigned G_LSB = 8;
  localparam int unsigned B_LSB = 0;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } feeder_state_e;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } pixel_t;

  function automatic pixel_t unpack_pixel(input logic [PIX_W-1:0] data);
    pixel_t p;
    p.r = data[R_LSB +: CH_W];
    p.g = data[G_LSB +: CH_W];
    p.b = data[B_LSB +: CH_W];
    return p;
  endfunction

endpackage

// File: rtl/rgb_pixel_fifo.sv
// Synchronous FIFO with combinational head read; DEPTH must be a power of two
// so the pointers wrap naturally.
module rgb_pixel_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             push_ok, pop_ok;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/rgb_pixel_feeder.sv
// Buffers RGB pixels and issues them one at a time to the grayscale converter,
// waiting for conv_done between pixels. Optional watchdog: RGB_PIXEL_FEEDER_TIMEOUT_EN.
module rgb_pixel_feeder
  import rgb_to_gray_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [PIX_W-1:0]           s_data,
  output logic                       conv_valid,
  output logic [CH_W-1:0]            conv_r,
  output logic [CH_W-1:0]            conv_g,
  output logic [CH_W-1:0]            conv_b,
  input  logic                       conv_done,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic                       timeout_err
);

  feeder_state_e    state_q;
  logic             conv_valid_q, busy_q;
  logic [CH_W-1:0]  conv_r_q, conv_g_q, conv_b_q;
  logic             fifo_full, fifo_empty, issue, wd_expire;
  logic [PIX_W-1:0] fifo_head;
  pixel_t           head_pix;

  rgb_pixel_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s_valid && !fifo_full),
    .pop   (issue),
    .din   (s_data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign s_ready    = !fifo_full;
  assign head_pix   = unpack_pixel(fifo_head);
  assign conv_valid = conv_valid_q;
  assign conv_r     = conv_r_q;
  assign conv_g     = conv_g_q;
  assign conv_b     = conv_b_q;
  assign busy       = busy_q;

  // The pop and the ISSUE entry happen on the same edge.
  assign issue = !fifo_empty &&
                 ((state_q == StIdle) || ((state_q == StWait) && conv_done));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      conv_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      conv_r_q     <= '0;
      conv_g_q     <= '0;
      conv_b_q     <= '0;
    end else begin
      conv_valid_q <= 1'b0;
      if (issue) begin
        state_q      <= StIssue;
        conv_valid_q <= 1'b1;
        busy_q       <= 1'b1;
        conv_r_q     <= head_pix.r;
        conv_g_q     <= head_pix.g;
        conv_b_q     <= head_pix.b;
      end else begin
        unique case (state_q)
          StIssue: state_q <= StWait;
          StWait: begin
            if (conv_done || wd_expire) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef RGB_PIXEL_FEEDER_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic            timeout_err_q;

  // Fires on the last WAIT cycle before the counter would reach the limit.
  assign wd_expire   = (state_q == StWait) && !conv_done &&
                       (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_q == StIssue) begin
        wd_cnt_q <= '0;
      end else if ((state_q == StWait) && !conv_done) begin
        wd_cnt_q <= wd_cnt_q + WD_W'(1);
      end
      if (wd_expire) begin
        timeout_err_q <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign wd_expire          = 1'b0;
  assign timeout_err        = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_rgb_pixel_feeder.sv
// Directed and random stimulus for rgb_pixel_feeder, checked every cycle against a
// queue-based behavioural model; honours RGB_PIXEL_FEEDER_TIMEOUT_EN if defined.
module tb_rgb_pixel_feeder;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [23:0] s_data = '0;
  logic        conv_valid;
  logic [7:0]  conv_r, conv_g, conv_b;
  logic        conv_done = 1'b0;
  logic        busy;
  logic [2:0]  fifo_level;
  logic        timeout_err;

  rgb_pixel_feeder #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .conv_valid  (conv_valid),
    .conv_r      (conv_r),
    .conv_g      (conv_g),
    .conv_b      (conv_b),
    .conv_done   (conv_done),
    .busy        (busy),
    .fifo_level  (fifo_level),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Behavioural model: queued pixels, one pixel in flight, cycles waited on it.
  logic [23:0] mq[$];
  logic        m_busy = 1'b0, m_valid = 1'b0, m_err = 1'b0, m_acc = 1'b0;
  logic [7:0]  m_r = '0, m_g = '0, m_b = '0;
  int          m_wcnt = 0;

  // Converter emulation and bookkeeping.
  logic auto_done = 1'b1, force_done = 1'b0, pending = 1'b0, check_gap = 1'b0;
  int   dcnt = 0, done_delay = 5, cycle = 0, last_issue = -1, issues = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("s_ready", 32'(s_ready), 32'(mq.size() != DEPTH));
    check("conv_valid", 32'(conv_valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_busy));
    check("fifo_level", 32'(fifo_level), 32'(mq.size()));
    check("conv_r", 32'(conv_r), 32'(m_r));
    check("conv_g", 32'(conv_g), 32'(m_g));
    check("conv_b", 32'(conv_b), 32'(m_b));
    check("timeout_err", 32'(timeout_err), 32'(m_err));
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy = 1'b0; m_valid = 1'b0; m_err = 1'b0;
    m_r = '0; m_g = '0; m_b = '0; m_wcnt = 0;
    pending = 1'b0; dcnt = 0;
  endtask

  // One clock: drive conv_done, advance model across the edge, then compare.
  task automatic step();
    logic fire, wait_ph, done_eff, issue;
    logic [23:0] pix;
    fire = auto_done && pending && (dcnt == 0);
    if (fire) pending = 1'b0;
    conv_done = force_done || fire;
    m_acc    = s_valid && (mq.size() != DEPTH);
    wait_ph  = m_busy && !m_valid;
    done_eff = wait_ph && conv_done;
    issue    = (mq.size() != 0) && (!m_busy || done_eff);
    @(posedge clk);
    cycle++;
    m_valid = 1'b0;
    if (issue) begin
      pix = mq.pop_front();
      {m_r, m_g, m_b} = pix;
      m_busy = 1'b1; m_valid = 1'b1; m_wcnt = 0;
    end else if (done_eff) begin
      m_busy = 1'b0;
    end else if (wait_ph) begin
`ifdef RGB_PIXEL_FEEDER_TIMEOUT_EN
      m_wcnt++;
      if (m_wcnt == TIMEOUT) begin
        m_busy = 1'b0;
        m_err  = 1'b1;
      end
`endif
    end
    if (m_acc) mq.push_back(s_data);
    #1;
    check_all();
    if (dcnt > 0) dcnt--;
    if (m_valid) begin
      issues++;
      if (check_gap && last_issue >= 0) check("issue_gap", 32'(cycle - last_issue), 32'd6);
      last_issue = cycle;
      pending = auto_done;
      dcnt = done_delay;
    end
  endtask

  task automatic push_n(input int n, input logic [23:0] base);
    int got = 0;
    for (int k = 0; k < 60 && got < n; k++) begin
      s_valid = 1'b1;
      s_data  = base + 24'(got * 24'h010203);
      step();
      if (m_acc) got++;
    end
    s_valid = 1'b0;
    check("push_accepts", 32'(got), 32'(n));
  endtask

  initial begin
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single pixel: issue two cycles after the push, idle again after conv_done.
    s_valid = 1'b1; s_data = 24'hFF8040;
    step();
    s_valid = 1'b0;
    step();
    check("single_valid", 32'(conv_valid), 32'd1);
    check("single_rgb", {8'h0, conv_r, conv_g, conv_b}, 32'h00FF8040);
    repeat (6) step();
    check("single_busy_end", 32'(busy), 32'd0);
    check("single_level_end", 32'(fifo_level), 32'd0);

    // Spurious conv_done while idle is ignored.
    force_done = 1'b1;
    repeat (3) step();
    force_done = 1'b0;
    step();
    check("spurious_busy", 32'(busy), 32'd0);
    check("spurious_level", 32'(fifo_level), 32'd0);

    // Burst of six with s_valid held; pulses six cycles apart.
    check_gap = 1'b1; last_issue = -1; issues = 0;
    push_n(6, 24'h102030);
    repeat (40) step();
    check("burst_issues", 32'(issues), 32'd6);
    check_gap = 1'b0;

    // Fill while stalled, then push while full during a pop.
    auto_done = 1'b0;
    push_n(5, 24'hA0B0C0);
    check("full_level", 32'(fifo_level), 32'd4);
    s_valid = 1'b1; s_data = 24'h5A5A5A; force_done = 1'b1;
    step();
    force_done = 1'b0;
    check("pop_full_level", 32'(fifo_level), 32'd3);
    check("pop_full_mready", 32'(m_acc), 32'd0);
    step();
    s_valid = 1'b0;
    check("refill_level", 32'(fifo_level), 32'd4);

    // Pop once more so WAIT holds 3 entries, then reset mid-WAIT.
    step();
    force_done = 1'b1;
    step();
    force_done = 1'b0;
    step();
    check("prereset_level", 32'(fifo_level), 32'd3);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    auto_done = 1'b1;
    repeat (10) step();
    check("postreset_valid", 32'(conv_valid), 32'd0);

    // Withhold conv_done: watchdog fires if built in, otherwise WAIT persists.
    auto_done = 1'b0;
    push_n(2, 24'h0C0D0E);
    repeat (20) step();
`ifdef RGB_PIXEL_FEEDER_TIMEOUT_EN
    check("wd_err", 32'(timeout_err), 32'd1);
`else
    check("wd_hold_busy", 32'(busy), 32'd1);
    check("wd_hold_err", 32'(timeout_err), 32'd0);
`endif
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    auto_done = 1'b1;

    // Random traffic with variable converter latency.
    for (int i = 0; i < 400; i++) begin
      s_valid    = 1'($urandom_range(0, 1));
      s_data     = 24'($urandom);
      done_delay = int'($urandom_range(1, 8));
      step();
    end
    s_valid = 1'b0;
    repeat (60) step();
    check("drain_level", 32'(fifo_level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/rgb_pixel_feeder.md
# rgb_pixel_feeder

Upstream stage of the RGB-to-grayscale converter. It accepts 24-bit RGB pixels from a ready/valid source and buffers them in a small FIFO. It presents one pixel at a time to the converter as a single-cycle `conv_valid` pulse with stable channel data, then waits for the converter's `output_valid` (`conv_done`) before issuing the next pixel. This gives full converter throughput: one pixel every 6 cycles.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 16: watchdog limit in WAIT (used only with the watchdog macro).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low; one clock domain.
- `s_valid`  in  1  source pixel valid.
- `s_ready`  out  1  feeder can accept (= FIFO not full).
- `s_data`  in  24  pixel {R[23:16], G[15:8], B[7:0]}.
- `conv_valid`  out  1  to converter `input_valid`; one-cycle pulse.
- `conv_r`, `conv_g`, `conv_b`  out  8 each  channel data; valid with `conv_valid`, then held.
- `conv_done`  in  1  from converter `output_valid`.
- `busy`  out  1  pixel in flight (ISSUE or WAIT).
- `fifo_level`  out  $clog2(DEPTH+1)  current FIFO occupancy.
- `timeout_err`  out  1  sticky watchdog flag; tied 0 when the watchdog is compiled out.

## Operation
- **Reset values:** state IDLE, FIFO empty, `fifo_level`=0, `s_ready`=1, `conv_valid`=0, `conv_r/g/b`=0, `busy`=0, `timeout_err`=0.
- **Push:** `s_valid && s_ready` at a rising edge writes `s_data` at the write pointer.
- **Pop:** occurs on the edge that enters ISSUE. The head entry is loaded into the `conv_r/g/b` registers.
- **Simultaneous push and pop:** level unchanged, both pointers advance.
- **Pointers:** wrap modulo DEPTH.
- **`s_ready`:** `s_ready = (fifo_level != DEPTH)`. It does not depend on a same-cycle pop, so a pop while full raises `s_ready` only in the next cycle.
- **States:**
  - IDLE: if FIFO non-empty, go to ISSUE (pop).
  - ISSUE: `conv_valid`=1; go to WAIT unconditionally.
  - WAIT: on `conv_done`, go to ISSUE (pop) if FIFO non-empty, else IDLE.
- **`conv_done` outside WAIT:** ignored.
- **`conv_r/g/b`:** change only on entry to ISSUE. They are held through WAIT.
- **`busy`:** 1 in ISSUE and WAIT.
- **Reset mid-operation:** FIFO contents are discarded and the in-flight pixel is abandoned. The converter shares `rst_n`, so both restart together.

## Timing
- Pixel accepted at edge E with feeder IDLE and FIFO empty: `conv_valid` is high in the cycle after E+1, i.e. 2 cycles of latency.
- `conv_valid` pulse at cycle T:
  - the converter asserts `conv_done` at T+5;
  - the next `conv_valid` is at T+6 if the FIFO holds data.
- Sustained rate: 1 pixel / 6 cycles; the FIFO absorbs bursts of up to DEPTH.
- `conv_valid` is never asserted in two consecutive cycles.

## Configuration
- Macro `RGB_PIXEL_FEEDER_TIMEOUT_EN`.
- **Defined:**
  - a counter clears on entry to WAIT and increments each cycle in WAIT without `conv_done`;
  - if it reaches `TIMEOUT_CYCLES`, `timeout_err` is set (sticky until reset) and the state goes to IDLE;
  - the abandoned pixel is dropped.
- **Undefined:** no counter; WAIT lasts indefinitely; `timeout_err` is tied to 0.

## Structure
- **Shared package `rgb_to_gray_pkg`:**
  - `CH_W`=8 and `PIX_W`=24;
  - feeder state encodings IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2;
  - channel slice offsets.
- **Sub-module `rgb_pixel_fifo`:** synchronous FIFO with parameters DEPTH and WIDTH. Ports: push, pop, din, dout (head, combinational read), full, empty, level.
- The FSM, output registers and watchdog live in the top module.

## Test plan
- **Single pixel:** push 0xFF8040 at cycle 0 → `conv_valid` at cycle 2 with R=0xFF, G=0x80, B=0x40; `conv_done` at 7 → `busy`=0 at 8, `fifo_level`=0.
- **Burst with held `s_valid`:** push 6 pixels with `s_valid` held, DEPTH=4 → `s_ready` drops after 4 accepts. All 6 are issued in order, with `conv_valid` pulses exactly 6 cycles apart when `conv_done` returns at T+5.
- **Push while full during pop:** FIFO full and pop occurs in the same cycle as `s_valid`=1 → that push is rejected (`s_ready`=0), accepted next cycle; `fifo_level` reads 3 then 4.
- **Spurious `conv_done` in IDLE:** state and level unchanged, no `conv_valid`.
- **Mid-WAIT reset:** `rst_n` low for 1 cycle during WAIT with 3 entries → all outputs at reset values and `fifo_level`=0 immediately; no `conv_valid` afterward without new pushes.
- **Watchdog:** with `RGB_PIXEL_FEEDER_TIMEOUT_EN`, withhold `conv_done` → `timeout_err`=1 16 cycles after entering WAIT, state IDLE, next queued pixel issued. Without the macro, WAIT persists and `timeout_err` stays 0.
